// File: rtl/motoro3_pwm_accum_gen.sv
// Multi-channel PWM generator with minimum-pulse and over-period carry, edge/center
// alignment, and per-frame want-minus-real on-time error reporting.
module motoro3_pwm_accum_gen #(
    parameter int unsigned CH     = 3,
    parameter int unsigned CNT_W  = 12,
    parameter int unsigned POS_W  = 16,
    parameter int unsigned CENTER = 0
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                enable,
    input  logic [CNT_W-1:0]    periodLen,
    input  logic [CNT_W-1:0]    minOn,
    input  logic [CH*POS_W-1:0] posReq,
    input  logic                frameEnd,
    output logic [CH-1:0]       pwm,
    output logic                periodStart,
    output logic [CH-1:0]       skipFlag,
    output logic [CH*POS_W-1:0] posLost
);
    localparam int unsigned CMP_W = ((POS_W > CNT_W) ? POS_W : CNT_W) + 1;

    typedef enum logic {StIdle, StRun} stateT;

    stateT               stateQ, stateD;
    logic [CNT_W-1:0]    phQ, phD;
    logic [CNT_W-1:0]    pLatQ, pLatD;
    logic [CNT_W-1:0]    pEff;
    logic [CNT_W-1:0]    onQ [CH];
    logic [CNT_W-1:0]    onD [CH];
    logic [CNT_W-1:0]    startQ [CH];
    logic [CNT_W-1:0]    startD [CH];
    logic [POS_W-1:0]    remQ [CH];
    logic [POS_W-1:0]    remD [CH];
    logic [POS_W-1:0]    wantQ [CH];
    logic [POS_W-1:0]    wantD [CH];
    logic [POS_W-1:0]    realQ [CH];
    logic [POS_W-1:0]    realD [CH];
    logic [CH-1:0]       pwmQ, pwmD;
    logic [CH-1:0]       skipQ, skipD;
    logic                periodStartQ, periodStartD;
    logic [CH*POS_W-1:0] lostQ, lostD;
    logic                newPeriod;

    // Phase-0 evaluation results, only consumed when newPeriod is set
    logic [POS_W:0]      sumRaw [CH];
    logic [POS_W-1:0]    sumSat [CH];
    logic [POS_W-1:0]    remBase [CH];
    logic [POS_W-1:0]    wantBase [CH];
    logic [POS_W-1:0]    evalRem [CH];
    logic [CNT_W-1:0]    evalOn [CH];
    logic [CNT_W-1:0]    evalStart [CH];
    logic [CH-1:0]       evalSkip;

    assign pEff = (periodLen < CNT_W'(2)) ? CNT_W'(2) : periodLen;

    always_comb begin
        evalSkip = '0;
        for (int i = 0; i < int'(CH); i++) begin
            // A frameEnd at this edge clears carry and want before the new period uses them
            remBase[i]  = (stateQ == StRun && !frameEnd) ? remQ[i] : '0;
            wantBase[i] = (stateQ == StRun && !frameEnd) ? wantQ[i] : '0;
            sumRaw[i]   = {1'b0, remBase[i]} + {1'b0, posReq[i*POS_W +: POS_W]};
            sumSat[i]   = sumRaw[i][POS_W] ? '1 : sumRaw[i][POS_W-1:0];
            evalOn[i]   = '0;
            if (sumSat[i] != '0) begin
                if (CMP_W'(sumSat[i]) < CMP_W'(minOn)) begin
                    evalSkip[i] = 1'b1;
                end else if (CMP_W'(sumSat[i]) > CMP_W'(pEff)) begin
                    evalOn[i] = pEff;
                end else begin
                    evalOn[i] = CNT_W'(sumSat[i]);
                end
            end
            evalRem[i]   = sumSat[i] - POS_W'(evalOn[i]);
            evalStart[i] = (CENTER != 0) ? ((pEff - evalOn[i]) >> 1) : '0;
        end
    end

    always_comb begin
        stateD       = stateQ;
        phD          = phQ;
        pLatD        = pLatQ;
        onD          = onQ;
        startD       = startQ;
        remD         = remQ;
        wantD        = wantQ;
        realD        = realQ;
        skipD        = skipQ;
        lostD        = lostQ;
        periodStartD = 1'b0;
        newPeriod    = 1'b0;
        pwmD         = '0;

        unique case (stateQ)
            StIdle: begin
                phD   = '0;
                skipD = '0;
                for (int i = 0; i < int'(CH); i++) begin
                    remD[i]  = '0;
                    wantD[i] = '0;
                    realD[i] = '0;
                end
                if (enable) begin
                    stateD    = StRun;
                    newPeriod = 1'b1;
                end
            end
            StRun: begin
                if (!enable) begin
                    stateD = StIdle;
                    phD    = '0;
                    skipD  = '0;
                    for (int i = 0; i < int'(CH); i++) begin
                        remD[i]  = '0;
                        wantD[i] = '0;
                        realD[i] = '0;
                    end
                end else begin
                    for (int i = 0; i < int'(CH); i++) begin
                        realD[i] = realQ[i] + POS_W'(pwmQ[i]);
                    end
                    if (frameEnd) begin
                        for (int i = 0; i < int'(CH); i++) begin
                            lostD[i*POS_W +: POS_W] = wantQ[i] - realD[i];
                            realD[i] = '0;
                            wantD[i] = '0;
                            remD[i]  = '0;
                        end
                        newPeriod = 1'b1;
                    end else if (phQ == pLatQ - CNT_W'(1)) begin
                        newPeriod = 1'b1;
                    end else begin
                        phD = phQ + CNT_W'(1);
                    end
                end
            end
        endcase

        if (newPeriod) begin
            phD          = '0;
            pLatD        = pEff;
            periodStartD = 1'b1;
            for (int i = 0; i < int'(CH); i++) begin
                onD[i]    = evalOn[i];
                startD[i] = evalStart[i];
                remD[i]   = evalRem[i];
                wantD[i]  = wantBase[i] + posReq[i*POS_W +: POS_W];
                skipD[i]  = evalSkip[i];
            end
        end

        // Output registers carry the value for the phase that the next cycle occupies
        for (int i = 0; i < int'(CH); i++) begin
            pwmD[i] = (stateD == StRun) && (phD >= startD[i]) &&
                      ({1'b0, phD} < ({1'b0, startD[i]} + {1'b0, onD[i]}));
        end
    end

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            stateQ       <= StIdle;
            phQ          <= '0;
            pLatQ        <= '0;
            pwmQ         <= '0;
            skipQ        <= '0;
            periodStartQ <= 1'b0;
            lostQ        <= '0;
            for (int i = 0; i < int'(CH); i++) begin
                onQ[i]    <= '0;
                startQ[i] <= '0;
                remQ[i]   <= '0;
                wantQ[i]  <= '0;
                realQ[i]  <= '0;
            end
        end else begin
            stateQ       <= stateD;
            phQ          <= phD;
            pLatQ        <= pLatD;
            pwmQ         <= pwmD;
            skipQ        <= skipD;
            periodStartQ <= periodStartD;
            lostQ        <= lostD;
            for (int i = 0; i < int'(CH); i++) begin
                onQ[i]    <= onD[i];
                startQ[i] <= startD[i];
                remQ[i]   <= remD[i];
                wantQ[i]  <= wantD[i];
                realQ[i]  <= realD[i];
            end
        end
    end

    assign pwm         = pwmQ;
    assign skipFlag    = skipQ;
    assign periodStart = periodStartQ;
    assign posLost     = lostQ;

endmodule

// File: tb/tb_motoro3_pwm_accum_gen.sv
// Bench for motoro3_pwm_accum_gen: scenario table, randomized run against a
// behavioural model, and hand-written frame/enable/reset sequences.
module tb_motoro3_pwm_accum_gen;
    localparam int CH    = 3;
    localparam int CNT_W = 12;
    localparam int POS_W = 16;
    localparam int MASK  = (1 << POS_W) - 1;

    logic                clk = 1'b0;
    logic                nRst;
    logic                enable;
    logic                frameEnd;
    logic [CNT_W-1:0]    periodLen;
    logic [CNT_W-1:0]    minOn;
    logic [CH*POS_W-1:0] posReq;
    logic [CH-1:0]       pwmE, skipE, pwmC, skipC;
    logic                psE, psC;
    logic [CH*POS_W-1:0] lostE, lostC;

    int tests = 0;
    int fails = 0;

    always #50 clk = ~clk;

    motoro3_pwm_accum_gen #(.CH(CH), .CNT_W(CNT_W), .POS_W(POS_W), .CENTER(0)) dutE (
        .clk(clk), .nRst(nRst), .enable(enable), .periodLen(periodLen), .minOn(minOn),
        .posReq(posReq), .frameEnd(frameEnd), .pwm(pwmE), .periodStart(psE),
        .skipFlag(skipE), .posLost(lostE)
    );

    motoro3_pwm_accum_gen #(.CH(CH), .CNT_W(CNT_W), .POS_W(POS_W), .CENTER(1)) dutC (
        .clk(clk), .nRst(nRst), .enable(enable), .periodLen(periodLen), .minOn(minOn),
        .posReq(posReq), .frameEnd(frameEnd), .pwm(pwmC), .periodStart(psC),
        .skipFlag(skipC), .posLost(lostC)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        nRst = 1'b0; enable = 1'b0; frameEnd = 1'b0;
        periodLen = '0; minOn = '0; posReq = '0;
        tick();
        tick();
        nRst = 1'b1;
    endtask

    // Behavioural model: per period, work out the pulse window from the carry rules
    int mRun, mPh, mP, mPs;
    int mReq [CH];
    int mRem [CH];
    int mWant [CH];
    int mOn [CH];
    int mSkip [CH];
    int mReal [2][CH];
    int mLost [2][CH];
    int mPwm [2][CH];

    task automatic modelClear(input bit full);
        mRun = 0; mPh = 0; mPs = 0;
        for (int i = 0; i < CH; i++) begin
            mRem[i] = 0; mWant[i] = 0; mSkip[i] = 0;
            for (int k = 0; k < 2; k++) begin
                mReal[k][i] = 0; mPwm[k][i] = 0;
                if (full) mLost[k][i] = 0;
            end
        end
    endtask

    task automatic modelNewPeriod();
        int sum;
        mPh = 0; mPs = 1;
        mP  = (periodLen < 2) ? 2 : int'(periodLen);
        for (int i = 0; i < CH; i++) begin
            sum = mRem[i] + mReq[i];
            if (sum > MASK) sum = MASK;
            if (sum == 0) begin
                mOn[i] = 0; mSkip[i] = 0;
            end else if (sum < int'(minOn)) begin
                mOn[i] = 0; mSkip[i] = 1;
            end else begin
                mOn[i] = (sum < mP) ? sum : mP; mSkip[i] = 0;
            end
            mRem[i]  = sum - mOn[i];
            mWant[i] = (mWant[i] + mReq[i]) & MASK;
        end
    endtask

    task automatic modelEdge();
        int st;
        for (int i = 0; i < CH; i++) mReq[i] = int'(posReq[i*POS_W +: POS_W]);
        if (mRun == 0) begin
            if (enable) begin
                mRun = 1;
                modelNewPeriod();
            end else begin
                modelClear(1'b0);
            end
        end else if (!enable) begin
            modelClear(1'b0);
        end else begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < CH; i++) mReal[k][i] = (mReal[k][i] + mPwm[k][i]) & MASK;
            if (frameEnd) begin
                for (int i = 0; i < CH; i++) begin
                    for (int k = 0; k < 2; k++) begin
                        mLost[k][i] = (mWant[i] - mReal[k][i]) & MASK;
                        mReal[k][i] = 0;
                    end
                    mWant[i] = 0; mRem[i] = 0;
                end
                modelNewPeriod();
            end else if (mPh == mP - 1) begin
                modelNewPeriod();
            end else begin
                mPh++; mPs = 0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < CH; i++) begin
                st = (k == 1) ? (mP - mOn[i]) / 2 : 0;
                mPwm[k][i] = (mRun != 0 && mPh >= st && mPh < st + mOn[i]) ? 1 : 0;
            end
        end
    endtask

    task automatic modelCompare();
        logic [CH-1:0]       expPwm, expSkip;
        logic [CH*POS_W-1:0] expLost;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < CH; i++) begin
                expPwm[i]  = mPwm[k][i][0];
                expSkip[i] = mSkip[i][0];
                expLost[i*POS_W +: POS_W] = POS_W'(mLost[k][i]);
            end
            check(k ? "rnd center pwm" : "rnd edge pwm", k ? pwmC : pwmE, expPwm);
            check(k ? "rnd center skip" : "rnd edge skip", k ? skipC : skipE, expSkip);
            check(k ? "rnd center periodStart" : "rnd edge periodStart", k ? psC : psE,
                  mPs[0]);
            check(k ? "rnd center posLost" : "rnd edge posLost", k ? lostC : lostE, expLost);
        end
    endtask

    typedef struct {
        int p; int pe; int mn; int req;
        int on0; int on1; int on2;
        logic [2:0] skip;  // bit k = period k suppressed
        int cStart;        // center-aligned first high phase in period 1, -1 if none
    } vecT;

    vecT vecs [6];

    initial begin
        vecs[0] = '{400, 400, 16, 100, 100, 100, 100, 3'b000, 150};
        vecs[1] = '{400, 400, 16, 10, 0, 20, 0, 3'b101, 190};
        vecs[2] = '{400, 400, 16, 500, 400, 400, 400, 3'b000, 0};
        vecs[3] = '{0, 2, 0, 1, 1, 1, 1, 3'b000, 0};
        vecs[4] = '{10, 10, 3, 4, 4, 4, 4, 3'b000, 3};
        vecs[5] = '{20, 20, 5, 0, 0, 0, 0, 3'b000, -1};

        nRst = 1'b0; enable = 1'b0; frameEnd = 1'b0;
        periodLen = '0; minOn = '0; posReq = '0;
        tick();
        check("reset pwm", {pwmE, pwmC}, '0);
        check("reset periodStart", {psE, psC}, '0);
        check("reset skip", {skipE, skipC}, '0);
        check("reset posLost", {lostE, lostC}, '0);

        for (int v = 0; v < 6; v++) begin
            int cntE, cntC, firstC, psCnt, onExp;
            doReset();
            periodLen = CNT_W'(vecs[v].p);
            minOn     = CNT_W'(vecs[v].mn);
            posReq    = {CH{POS_W'(vecs[v].req)}};
            enable    = 1'b1;
            for (int k = 0; k < 3; k++) begin
                cntE = 0; cntC = 0; firstC = -1; psCnt = 0;
                onExp = (k == 0) ? vecs[v].on0 : (k == 1) ? vecs[v].on1 : vecs[v].on2;
                for (int ph = 0; ph < vecs[v].pe; ph++) begin
                    tick();
                    if (pwmE[0]) cntE++;
                    if (pwmC[0]) begin
                        cntC++;
                        if (firstC < 0) firstC = ph;
                    end
                    if (psE) psCnt++;
                    if (ph == 0) begin
                        check("tbl periodStart at phase 0", psE, 1'b1);
                        check("tbl skip at phase 0", skipE[0], vecs[v].skip[k]);
                    end
                    if (ph == vecs[v].pe - 1)
                        check("tbl skip at last phase", skipC[0], vecs[v].skip[k]);
                end
                check("tbl edge on-count", cntE, onExp);
                check("tbl center on-count", cntC, onExp);
                check("tbl periodStart count", psCnt, 1);
                if (k == 1) check("tbl center start", firstC, vecs[v].cStart);
            end
            enable = 1'b0;
            tick();
            check("tbl disable pwm", {pwmE, pwmC}, '0);
        end

        doReset();
        modelClear(1'b1);
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom_range(0, 59) != 0);
            frameEnd  = ($urandom_range(0, 24) == 0);
            periodLen = CNT_W'($urandom_range(0, 24));
            minOn     = CNT_W'($urandom_range(0, 10));
            for (int i = 0; i < CH; i++)
                posReq[i*POS_W +: POS_W] = ($urandom_range(0, 9) == 0) ?
                    POS_W'($urandom_range(0, MASK)) : POS_W'($urandom_range(0, 30));
            modelEdge();
            tick();
            modelCompare();
        end

        // Frame error: three periods of posReq=10 / minOn=16, frameEnd on the last phase
        doReset();
        periodLen = CNT_W'(400); minOn = CNT_W'(16); posReq = {CH{POS_W'(10)}};
        enable = 1'b1;
        tick();
        check("frame first period skip", skipE, 3'b111);
        repeat (1199) tick();
        frameEnd = 1'b1;
        tick();
        frameEnd = 1'b0;
        check("frame posLost edge", lostE, {CH{POS_W'(10)}});
        check("frame posLost center", lostC, {CH{POS_W'(10)}});
        check("frame forced phase 0 start", psE, 1'b1);
        check("frame rem cleared skip", skipE, 3'b111);
        check("frame rem cleared pwm", pwmE, 3'b000);

        // Enable abort and restart
        posReq = {CH{POS_W'(100)}};
        repeat (400) tick();
        check("abort pre pulse start", psE, 1'b1);
        check("abort pre pulse pwm", pwmE, 3'b111);
        repeat (5) tick();
        check("abort mid pulse pwm", pwmE, 3'b111);
        enable = 1'b0;
        tick();
        check("abort pwm low", {pwmE, pwmC}, '0);
        check("abort periodStart low", psE, 1'b0);
        check("abort skip low", skipE, 3'b000);
        check("abort posLost held", lostE, {CH{POS_W'(10)}});
        enable = 1'b1;
        tick();
        check("restart periodStart", psE, 1'b1);
        check("restart edge pwm", pwmE, 3'b111);
        check("restart center pwm", pwmC, 3'b000);

        // Asynchronous reset mid-pulse
        repeat (3) tick();
        check("reset pre pwm", pwmE, 3'b111);
        nRst = 1'b0;
        #5;
        check("async reset pwm", {pwmE, pwmC}, '0);
        check("async reset posLost", {lostE, lostC}, '0);
        check("async reset skip", {skipE, skipC}, '0);
        tick();
        nRst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/motoro3_pwm_accum_gen.md
# motoro3_pwm_accum_gen

Parametrised multi-channel PWM generator for the 3-phase motor drive. Sits between the commutation/step sequencer, which supplies per-channel on-time requests, and the MOS gate drivers. Each channel has a shared, programmable period and a minimum-pulse rule: on-time shorter than the minimum is not emitted but carried forward. The block also carries forward on-time that exceeds the period, supports edge- or center-aligned pulses, and reports the want-minus-real on-time error per commutation frame.

## Interface
Parameters:
- CH, 3, number of PWM channels
- CNT_W, 12, period/phase counter width
- POS_W, 16, on-time request, remainder and accumulator width
- CENTER, 0, 0 = edge-aligned pulses, 1 = center-aligned pulses

Ports:
- clk  in  1  system clock, 10 MHz; all flops update on falling edge of clk
- nRst  in  1  asynchronous active-low reset
- enable  in  1  run request; low forces idle
- periodLen  in  CNT_W  period length in clocks; sampled at each phase-0 entry; values <2 treated as 2
- minOn  in  CNT_W  minimum emitted pulse length in clocks
- posReq  in  CH*POS_W  per-channel requested on-time per period, unsigned; channel i at bits [i*POS_W +: POS_W]
- frameEnd  in  1  one-cycle strobe at the end of a commutation frame
- pwm  out  CH  gate drive outputs, registered
- periodStart  out  1  high during phase 0 of every period
- skipFlag  out  CH  per channel: this period's pulse was suppressed by the minOn rule
- posLost  out  CH*POS_W  per channel want−real on-time of the last completed frame, two's complement

## Operation
- States: IDLE and RUN.
  - IDLE is entered on reset and whenever enable=0.
  - IDLE→RUN when enable is sampled 1. The next cycle is phase 0.
  - RUN→IDLE when enable is sampled 0. pwm is 0 from the next cycle.
  - In IDLE: phase held at 0, remainder/want/real cleared, pwm=0, skipFlag=0, periodStart=0, posLost holds.
- Phase counter ph counts 0..P−1, where P is the latched periodLen. After P−1 it wraps to 0 and P is re-latched.
- At each phase-0 entry, per channel:
  - sum = rem + posReq. Saturates at 2^POS_W−1.
  - If sum == 0: on = 0, skipFlag = 0.
  - Else if sum < minOn: on = 0, rem ← sum, skipFlag = 1.
  - Else: on = min(sum, P), rem ← sum − on, skipFlag = 0.
  - want ← want + posReq (wraps).
- Pulse placement:
  - CENTER=0: start = 0.
  - CENTER=1: start = (P − on) >> 1.
  - pwm[i] = 1 for phases [start, start+on), otherwise 0.
- Each cycle with pwm[i]=1 adds 1 to real[i] (wraps).
- frameEnd (RUN only), at the same edge:
  - posLost[i] ← want[i] − real[i], using the values including this cycle's pwm contribution.
  - want, real and rem are cleared.
  - ph is forced so the next cycle is phase 0. That phase-0 evaluation uses rem = 0.
  - The in-progress pulse is truncated: pwm drops in the next cycle unless the new period re-asserts it.
- frameEnd in IDLE is ignored.
- Simultaneous phase-0 entry and frameEnd: frameEnd wins. The request for that phase 0 is evaluated once, in the forced phase 0 that follows.
- Changes to posReq, minOn or periodLen mid-period do not affect the running period.

## Timing
- Reset values: pwm=0, periodStart=0, skipFlag=0, posLost=0, state IDLE, internal counters 0.
- enable sampled high at edge n: phase 0 occupies cycle n+1. periodStart and any pwm with start=0 are high in that same cycle.
- periodStart, skipFlag and pwm come from registers. No combinational path from inputs to outputs.
- skipFlag is valid from phase 0 through phase P−1 of its period.
- posLost updates on the edge that samples frameEnd and is visible the next cycle.
- Reset asserted mid-period: all outputs go to reset values immediately (asynchronous).

## Test plan
- Edge-aligned: P=400, minOn=16, posReq=100 on all channels → each period pwm high for phases 0–99, low for 100–399; periodStart high once every 400 clocks.
- Minimum carry: posReq=10, minOn=16 → period 1 has no pulse and skipFlag=1; period 2 pulses for 20 clocks with skipFlag=0; period 3 is skipped again.
- Over-period carry: P=400, posReq=500 → period 1 pulses 400 (rem 100), period 2 pulses 400 (rem 200); the pulse stays continuously high across period boundaries.
- Center-aligned: CENTER=1, P=400, posReq=100 → pwm high for phases 150–249 only.
- Frame error: posReq=10, minOn=16, three periods then frameEnd at the last phase of period 3 → posLost = 10 (want 30, real 20). The next period starts with rem=0.
- Reset/enable abort: drop nRst mid-pulse → pwm=0 and posLost=0 immediately. Separately, drop enable mid-pulse → pwm=0 the next cycle, posLost retains its last value, and re-enable restarts at phase 0.
